// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared sample type, pacer state encoding and constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } pacer_state_t;

  localparam int MIN_SAMPLE_PERIOD = 4;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO with occupancy count and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign empty  = (count == '0);
  assign w_push = push & (count != FULL_COUNT) & ~flush;
  assign w_pop  = pop & ~empty & ~flush;
  assign rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      count <= count + (AW+1)'(1);
      else if (w_pop && !w_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_sample_pacer.sv
// ============================================================================
// Module      : dram_sample_pacer
// Description : Buffers DRAM sample words and emits one paced pulse per period.
//               Define DRAM_SAMPLE_PACER_HOLD_EN to repeat the last sample on
//               underrun instead of emitting zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_sample_pacer
  import audio_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PERIOD_W    = 14,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] sample_period_in,
  input  logic [15:0]         stream_data,
  input  logic                stream_last,
  input  logic                stream_valid,
  output logic                stream_ready,
  output sample_t             sample_out,
  output logic                sample_out_valid,
  output logic [PERIOD_W-1:0] sample_period_out,
  output logic                busy,
  output logic [15:0]         underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]         FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]         PRIME_COUNT = (AW+1)'(PRIME_LEVEL);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD  = PERIOD_W'(MIN_SAMPLE_PERIOD);

  pacer_state_t        r_state;
  logic [PERIOD_W-1:0] r_counter;

  logic [16:0]         w_fifo_rdata;
  logic [AW:0]         w_fifo_count;
  logic                w_fifo_empty;
  logic [AW:0]         w_cnt_next;
  logic                w_push;
  logic                w_tick;
  logic                w_pop;
  logic                w_prime_done;
  logic [PERIOD_W-1:0] w_period_clamped;
  sample_t             w_underrun_value;

  assign stream_ready     = (r_state != IDLE) && (w_fifo_count != FULL_COUNT) && !start;
  assign w_push           = stream_valid & stream_ready;
  assign w_tick           = (r_state == PLAY) && (r_counter == sample_period_out - PERIOD_W'(1));
  assign w_pop            = w_tick & ~w_fifo_empty & ~start;
  assign w_cnt_next       = w_fifo_count + (AW+1)'(w_push);
  assign w_prime_done     = (w_cnt_next >= PRIME_COUNT) || (w_push && stream_last);
  assign w_period_clamped = (sample_period_in < MIN_PERIOD) ? MIN_PERIOD : sample_period_in;

  sync_fifo #(
    .WIDTH (17),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({stream_last, stream_data}),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .empty (w_fifo_empty)
  );

`ifdef DRAM_SAMPLE_PACER_HOLD_EN
  // Last really-popped sample; restarts at zero on every start.
  sample_t r_held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_held <= '0;
    else if (start) r_held <= '0;
    else if (w_pop) r_held <= w_fifo_rdata[15:0];
  end

  assign w_underrun_value = r_held;
`else
  assign w_underrun_value = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= IDLE;
      r_counter         <= '0;
      busy              <= 1'b0;
      sample_out        <= '0;
      sample_out_valid  <= 1'b0;
      sample_period_out <= '0;
      underrun_count    <= '0;
    end else begin
      sample_out_valid <= 1'b0;
      if (start) begin
        // Retrigger wins over any tick landing in the same cycle.
        sample_period_out <= w_period_clamped;
        r_counter         <= '0;
        r_state           <= PRIME;
        busy              <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_counter <= '0;
          end
          PRIME: begin
            if (w_prime_done) begin
              r_state   <= PLAY;
              r_counter <= '0;
            end
          end
          PLAY: begin
            r_counter <= w_tick ? '0 : r_counter + PERIOD_W'(1);
            if (w_tick) begin
              sample_out_valid <= 1'b1;
              if (!w_fifo_empty) begin
                sample_out <= w_fifo_rdata[15:0];
                if (w_fifo_rdata[16]) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                end
              end else begin
                sample_out <= w_underrun_value;
                if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
